// File: rtl/edib_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | edib_tx_if : request/serial-line bundle between a frame source and edib_tx. |
// | Optional EDIB_TX_PARITY_ERR_INJ_EN adds the ParityErrInj request bit.       |
// | Revision   : 1.0                                                            |
// +----------------------------------------------------------------------------+
interface edib_tx_if;
    logic        TxStart;
    logic        TxType;
    logic [15:0] TxData;
`ifdef EDIB_TX_PARITY_ERR_INJ_EN
    logic        ParityErrInj;
`endif
    logic        CMDOut;
    logic        TxBusy;
    logic        TxDone;
    logic [3:0]  State;

`ifdef EDIB_TX_PARITY_ERR_INJ_EN
    modport master (output TxStart, TxType, TxData, ParityErrInj,
                    input  CMDOut, TxBusy, TxDone, State);
    modport slave  (input  TxStart, TxType, TxData, ParityErrInj,
                    output CMDOut, TxBusy, TxDone, State);
`else
    modport master (output TxStart, TxType, TxData,
                    input  CMDOut, TxBusy, TxDone, State);
    modport slave  (input  TxStart, TxType, TxData,
                    output CMDOut, TxBusy, TxDone, State);
`endif
endinterface
`default_nettype wire

// File: rtl/edib_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | edib_tx : serial frame transmitter (6-bit sync, 17 complemented bit pairs,  |
// |           idle-high gap). EDIB_TX_PARITY_ERR_INJ_EN enables parity inject.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module edib_tx #(
    parameter int BIT_CYCLES = 576,
    parameter int GAP_BITS   = 2
) (
    input  logic      Clk,
    input  logic      Rstn,
    edib_tx_if.slave  bus
);

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        SYNC = 4'b0010,
        DATA = 4'b0100,
        GAP  = 4'b1000
    } state_t;

    localparam logic [11:0] BIT_LAST  = 12'(BIT_CYCLES - 1);
    localparam logic [5:0]  SYNC_LAST = 6'd5;
    localparam logic [5:0]  DATA_LAST = 6'd33;
    localparam logic [5:0]  GAP_LAST  = 6'(GAP_BITS - 1);

    state_t      state_q, state_d;
    logic [11:0] cyc_cnt_q, cyc_cnt_d;
    logic [5:0]  bit_idx_q, bit_idx_d;
    logic        type_q, type_d;
    logic [15:0] data_q, data_d;
    logic        inj_q, inj_d;
    logic        cmd_out_q, cmd_out_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        inj_in;
    logic        bit_end;
    logic        data_bit;
    logic        parity_bit;

`ifdef EDIB_TX_PARITY_ERR_INJ_EN
    assign inj_in = bus.ParityErrInj;
`else
    assign inj_in = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            state_q   <= IDLE;
            cyc_cnt_q <= '0;
            bit_idx_q <= '0;
            type_q    <= 1'b0;
            data_q    <= '0;
            inj_q     <= 1'b0;
            cmd_out_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_cnt_q <= cyc_cnt_d;
            bit_idx_q <= bit_idx_d;
            type_q    <= type_d;
            data_q    <= data_d;
            inj_q     <= inj_d;
            cmd_out_q <= cmd_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cyc_cnt_d  = cyc_cnt_q;
        bit_idx_d  = bit_idx_q;
        type_d     = type_q;
        data_d     = data_q;
        inj_d      = inj_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cmd_out_d  = 1'b1;
        bit_end    = (cyc_cnt_q == BIT_LAST);

        // Shared bit timing for every active state; last-bit cases override below.
        if (state_q != IDLE) begin
            cyc_cnt_d = bit_end ? 12'd0 : cyc_cnt_q + 12'd1;
            bit_idx_d = bit_end ? bit_idx_q + 6'd1 : bit_idx_q;
        end

        case (state_q)
            IDLE: begin
                if (bus.TxStart) begin
                    state_d   = SYNC;
                    cyc_cnt_d = '0;
                    bit_idx_d = '0;
                    type_d    = bus.TxType;
                    data_d    = bus.TxData;
                    inj_d     = inj_in;
                    busy_d    = 1'b1;
                end
            end
            SYNC: begin
                if (bit_end && bit_idx_q == SYNC_LAST) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_end && bit_idx_q == DATA_LAST) begin
                    state_d   = GAP;
                    bit_idx_d = '0;
                end
            end
            GAP: begin
                if (bit_end && bit_idx_q == GAP_LAST) begin
                    state_d   = IDLE;
                    bit_idx_d = '0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                cyc_cnt_d = '0;
                bit_idx_d = '0;
                busy_d    = 1'b0;
            end
        endcase

        // Line level is derived from the next state so CMDOut changes on the bit edge itself.
        data_bit   = data_d[4'd15 - bit_idx_d[4:1]];
        parity_bit = ~(^data_d) ^ inj_d;
        case (state_d)
            SYNC:    cmd_out_d = (bit_idx_d < 6'd3) ? ~type_d : type_d;
            DATA:    cmd_out_d = (bit_idx_d < 6'd32) ? (data_bit ^ bit_idx_d[0])
                                                     : (parity_bit ^ bit_idx_d[0]);
            default: cmd_out_d = 1'b1;
        endcase
    end

    assign bus.CMDOut = cmd_out_q;
    assign bus.TxBusy = busy_q;
    assign bus.TxDone = done_q;
    assign bus.State  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_edib_tx.sv
`default_nettype none
// Bench for edib_tx: a fast instance runs a table of frames plus corner sequences,
// a default-parameter instance sends the reference 0xA5C3 command frame.
module tb_edib_tx;

    localparam int FBC  = 12;
    localparam int FGAP = 3;
    localparam int FLEN = (40 + FGAP) * FBC;
    localparam int SBC  = 576;
    localparam int SGAP = 2;
    localparam int SLEN = (40 + SGAP) * SBC;

    typedef struct packed {
        logic        tx_type;
        logic [15:0] tx_data;
        logic        inj;
        logic [5:0]  exp_sync;
        logic        exp_p;
        logic        poke;
    } vec_t;

    logic Clk    = 1'b0;
    logic rstn_f = 1'b0;
    logic rstn_s = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[6];

    edib_tx_if fif();
    edib_tx_if sif();

    edib_tx #(.BIT_CYCLES(FBC), .GAP_BITS(FGAP)) u_fast (
        .Clk  (Clk),
        .Rstn (rstn_f),
        .bus  (fif.slave)
    );

    edib_tx u_slow (
        .Clk  (Clk),
        .Rstn (rstn_s),
        .bus  (sif.slave)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic model_bit(input vec_t v, input logic p, input int k);
        if (k < 6)  return v.exp_sync[5 - k];
        if (k < 38) return v.tx_data[15 - (k - 6) / 2] ^ (((k - 6) % 2) == 1);
        if (k < 40) return p ^ (k == 39);
        return 1'b1;
    endfunction

    // Loopback receiver: decodes sync type, data, parity and pair-coding errors.
    task automatic decode(input logic [39:0] rx, output logic typ, output logic [15:0] d,
                          output logic perr, output logic cod_err);
        logic [5:0] sync;
        logic       p;
        sync    = rx[39:34];
        cod_err = !(sync == 6'b111000 || sync == 6'b000111);
        typ     = (sync == 6'b000111);
        d       = '0;
        p       = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (rx[33 - 2*i] == rx[32 - 2*i]) cod_err = 1'b1;
            if (i < 16) d[15 - i] = rx[33 - 2*i];
            else        p         = rx[33 - 2*i];
        end
        perr = ~(^{d, p});
    endtask

    task automatic run_frame(input vec_t v);
        logic        p_exp, perr_exp, typ, perr, cod_err;
        logic [15:0] d;
        logic [39:0] rx;
        int          bad_line, bad_busy, bad_done, bad_idle, k;
        p_exp    = v.exp_p;
        perr_exp = 1'b0;
        bad_line = 0; bad_busy = 0; bad_done = 0; bad_idle = 0;
        rx       = '1;
`ifdef EDIB_TX_PARITY_ERR_INJ_EN
        fif.ParityErrInj = v.inj;
        if (v.inj) begin
            p_exp    = ~v.exp_p;
            perr_exp = 1'b1;
        end
`endif
        fif.TxType  = v.tx_type;
        fif.TxData  = v.tx_data;
        fif.TxStart = 1'b1;
        @(posedge Clk); #1;
        fif.TxStart = 1'b0;
        check("latency_state", fif.State, 4'b0010);
        for (int e = 0; e < FLEN; e++) begin
            k = e / FBC;
            if (fif.CMDOut !== model_bit(v, p_exp, k)) bad_line++;
            if (fif.TxBusy !== 1'b1) bad_busy++;
            if (fif.TxDone !== 1'b0) bad_done++;
            if ((e % FBC) == FBC / 2 && k < 40) rx[39 - k] = fif.CMDOut;
            if (v.poke && e == 16 * FBC + 3) begin
                fif.TxStart = 1'b1;
                fif.TxType  = ~v.tx_type;
                fif.TxData  = ~v.tx_data;
            end
            if (v.poke && e == 16 * FBC + 4) fif.TxStart = 1'b0;
            @(posedge Clk); #1;
        end
        check("line_bits", bad_line, 0);
        check("busy_during_frame", bad_busy, 0);
        check("no_early_done", bad_done, 0);
        check("done_pulse", fif.TxDone, 1'b1);
        check("busy_fall", fif.TxBusy, 1'b0);
        check("idle_after_frame", fif.State, 4'b0001);
        decode(rx, typ, d, perr, cod_err);
        check("rx_data", d, v.tx_data);
        check("rx_type", typ, v.tx_type);
        check("rx_parity_err", perr, perr_exp);
        check("rx_coding_err", cod_err, 1'b0);
        @(posedge Clk); #1;
        check("done_width", fif.TxDone, 1'b0);
        if (v.poke) begin
            for (int e = 0; e < 2 * FBC; e++) begin
                if (fif.State !== 4'b0001 || fif.CMDOut !== 1'b1) bad_idle++;
                @(posedge Clk); #1;
            end
            check("no_second_frame", bad_idle, 0);
        end
    endtask

    task automatic fast_seq();
        int  bad, n, n_done;
        logic seen_done, restarted;
        vecs[0] = '{1'b0, 16'hA5C3, 1'b0, 6'b111000, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 16'hFFFF, 1'b0, 6'b000111, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 16'h0001, 1'b0, 6'b111000, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 16'h0000, 1'b1, 6'b000111, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 16'h8000, 1'b0, 6'b000111, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 16'h1234, 1'b0, 6'b111000, 1'b0, 1'b0};
        fif.TxStart = 1'b0; fif.TxType = 1'b0; fif.TxData = '0;
`ifdef EDIB_TX_PARITY_ERR_INJ_EN
        fif.ParityErrInj = 1'b0;
`endif
        repeat (3) @(posedge Clk);
        #1;
        check("reset_state", fif.State, 4'b0001);
        check("reset_line", fif.CMDOut, 1'b1);
        check("reset_busy", fif.TxBusy, 1'b0);
        check("reset_done", fif.TxDone, 1'b0);
        rstn_f = 1'b1;
        for (int i = 0; i < 5; i++) run_frame(vecs[i]);

        // Abort at DATA bit 10, then a clean frame after release.
        fif.TxType = 1'b1; fif.TxData = 16'hBEEF; fif.TxStart = 1'b1;
        @(posedge Clk); #1;
        fif.TxStart = 1'b0;
        repeat (16 * FBC + FBC / 2) @(posedge Clk);
        #1;
        check("abort_in_data", fif.State, 4'b0100);
        rstn_f = 1'b0;
        #1;
        check("abort_line", fif.CMDOut, 1'b1);
        check("abort_state", fif.State, 4'b0001);
        check("abort_busy", fif.TxBusy, 1'b0);
        bad = 0;
        for (int e = 0; e < 3; e++) begin
            @(posedge Clk); #1;
            if (fif.TxDone !== 1'b0 || fif.State !== 4'b0001) bad++;
        end
        rstn_f = 1'b1;
        for (int e = 0; e < 3 * FBC; e++) begin
            @(posedge Clk); #1;
            if (fif.TxDone !== 1'b0 || fif.State !== 4'b0001) bad++;
        end
        check("abort_no_done", bad, 0);
        run_frame(vecs[5]);

        // Held TxStart: frames restart after exactly one IDLE cycle.
        fif.TxType = 1'b0; fif.TxData = 16'h00F0; fif.TxStart = 1'b1;
        @(posedge Clk); #1;
        n = 0; n_done = 0; seen_done = 1'b0; restarted = 1'b0;
        for (int i = 0; i < FLEN + 10 && !restarted; i++) begin
            @(posedge Clk); #1;
            n++;
            if (fif.TxDone === 1'b1 && !seen_done) begin
                seen_done = 1'b1;
                n_done    = n;
            end else if (seen_done && fif.State === 4'b0010) begin
                restarted = 1'b1;
            end
        end
        fif.TxStart = 1'b0;
        check("b2b_done_time", n_done, FLEN);
        check("b2b_restart_time", n, FLEN + 1);
        seen_done = 1'b0;
        for (int i = 0; i < FLEN + 10 && !seen_done; i++) begin
            @(posedge Clk); #1;
            if (fif.TxDone === 1'b1) seen_done = 1'b1;
        end
        check("b2b_second_done", seen_done, 1'b1);
    endtask

    task automatic slow_seq();
        logic [39:0] exp_frame;
        logic        eb;
        int          bad_line, bad_busy, bad_done;
        bad_line = 0; bad_busy = 0; bad_done = 0;
        exp_frame = 40'b111000_10011001_01100110_10100101_01011010_10;
        sif.TxStart = 1'b0; sif.TxType = 1'b0; sif.TxData = '0;
`ifdef EDIB_TX_PARITY_ERR_INJ_EN
        sif.ParityErrInj = 1'b0;
`endif
        repeat (2) @(posedge Clk);
        #1;
        check("slow_reset_line", sif.CMDOut, 1'b1);
        rstn_s = 1'b1;
        sif.TxData  = 16'hA5C3;
        sif.TxStart = 1'b1;
        @(posedge Clk); #1;
        sif.TxStart = 1'b0;
        for (int e = 0; e < SLEN; e++) begin
            eb = (e / SBC < 40) ? exp_frame[39 - e / SBC] : 1'b1;
            if (sif.CMDOut !== eb) bad_line++;
            if (sif.TxBusy !== 1'b1) bad_busy++;
            if (sif.TxDone !== 1'b0) bad_done++;
            @(posedge Clk); #1;
        end
        check("slow_line_bits", bad_line, 0);
        check("slow_busy", bad_busy, 0);
        check("slow_no_early_done", bad_done, 0);
        check("slow_done_pulse", sif.TxDone, 1'b1);
        check("slow_idle", sif.State, 4'b0001);
        @(posedge Clk); #1;
        check("slow_done_width", sif.TxDone, 1'b0);
    endtask

    initial begin
        fork
            slow_seq();
            fast_seq();
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
